dual_issue_scoreboard: RTL and testbench

- Issue controller for the dual-issue five-stage MIPS core.
- Each cycle, decode presents a pair: slot 0 (ALU/ADDI/BEQ/BNE) and slot 1 (LW/SW).
- The block tracks in-flight load destinations in a per-register countdown scoreboard. From that it decides whether to issue both slots, issue slot 0 alone and split the pair, or stall.
- It drives fetch/decode hold and per-slot issue enables, which zero the control fields of a squashed slot at the ID/EX register.

---
 rtl/dual_issue_scoreboard_pkg.sv | 31 +++
 rtl/dual_issue_scoreboard_if.sv | 38 +++
 rtl/dual_issue_scoreboard_pend_table.sv | 40 ++++
 rtl/dual_issue_scoreboard.sv | 99 +++++++++
 tb/tb_dual_issue_scoreboard.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dual_issue_scoreboard_pkg.sv
// Shared types and constants for the dual-issue scoreboard and its decode-side users.
package dual_issue_scoreboard_pkg;

  typedef enum logic {
    ST_PAIR  = 1'b0,
    ST_SPLIT = 1'b1
  } state_t;

  localparam int              REG_W        = 5;
  localparam logic [REG_W-1:0] REG_ZERO    = '0;
  localparam int              LOAD_LAT_DEF = 1;

  // Primary opcode classes decode uses to derive the slot control bits.
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  // Slot-0 instruction writes a register (R-type or ADDI).
  function automatic logic op_s0_wr(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_ADDI);
  endfunction

  // Slot-0 instruction reads rt as a source (R-type, branches).
  function automatic logic op_s0_uses_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/dual_issue_scoreboard_if.sv
// Decode <-> issue-controller bundle: the decoded pair, flush, and the issue decisions.
interface dual_issue_scoreboard_if
  import dual_issue_scoreboard_pkg::*;
#(
  parameter int CNT_W = 16
) ();

  logic             flush;
  logic             s0_valid;
  logic [REG_W-1:0] s0_rs;
  logic [REG_W-1:0] s0_rt;
  logic             s0_uses_rt;
  logic             s0_wr;
  logic [REG_W-1:0] s0_dst;
  logic             s1_valid;
  logic             s1_load;
  logic             s1_store;
  logic [REG_W-1:0] s1_rs;
  logic [REG_W-1:0] s1_rt;
  logic             iss0;
  logic             iss1;
  logic             hold;
  logic             split;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output flush, s0_valid, s0_rs, s0_rt, s0_uses_rt, s0_wr, s0_dst,
           s1_valid, s1_load, s1_store, s1_rs, s1_rt,
    input  iss0, iss1, hold, split, stall_cnt
  );

  modport slave (
    input  flush, s0_valid, s0_rs, s0_rt, s0_uses_rt, s0_wr, s0_dst,
           s1_valid, s1_load, s1_store, s1_rs, s1_rt,
    output iss0, iss1, hold, split, stall_cnt
  );

endinterface

// File: rtl/dual_issue_scoreboard_pend_table.sv
// Per-register load countdown table with four combinational busy read ports.
module dual_issue_scoreboard_pend_table
  import dual_issue_scoreboard_pkg::*;
#(
  parameter int NREG     = 32,
  parameter int LOAD_LAT = LOAD_LAT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic [REG_W-1:0]      set_idx,
  input  logic                  clr_en,
  input  logic [REG_W-1:0]      clr_idx,
  input  logic [3:0][REG_W-1:0] rd_idx,
  output logic [3:0]            rd_busy
);

  localparam int PW = (LOAD_LAT < 1) ? 1 : $clog2(LOAD_LAT + 1);

  logic [PW-1:0] pend [NREG];

  // Per entry: load set beats slot-0 clear beats aging; entry 0 is never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) pend[r] <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (set_en && set_idx == REG_W'(r))      pend[r] <= PW'(LOAD_LAT);
        else if (clr_en && clr_idx == REG_W'(r)) pend[r] <= '0;
        else if (pend[r] != '0)                  pend[r] <= pend[r] - PW'(1);
      end
    end
  end

  // A register is unreadable while its countdown is nonzero.
  always_comb begin
    for (int i = 0; i < 4; i++) rd_busy[i] = (pend[rd_idx[i]] != '0);
  end

endmodule

// File: rtl/dual_issue_scoreboard.sv
// Issue controller for the dual-issue pair: pair/split/stall decision over a load scoreboard.
module dual_issue_scoreboard
  import dual_issue_scoreboard_pkg::*;
#(
  parameter int NREG     = 32,
  parameter int LOAD_LAT = LOAD_LAT_DEF,
  parameter int CNT_W    = 16
) (
  input  logic clk,
  input  logic rst,
  dual_issue_scoreboard_if.slave bus
);

  state_t                  state, state_nxt;
  logic [3:0][REG_W-1:0]   rd_idx;
  logic [3:0]              busy;
  logic                    blk0, blk1, cnf;
  logic                    iss0, iss1, hold;
  logic                    set_en, clr_en;
  logic [CNT_W-1:0]        stall_cnt;

  // Read ports: [0]=s0_rs [1]=s0_rt [2]=s1_rs [3]=s1_rt
  assign rd_idx = {bus.s1_rt, bus.s1_rs, bus.s0_rt, bus.s0_rs};

  dual_issue_scoreboard_pend_table #(
    .NREG     (NREG),
    .LOAD_LAT (LOAD_LAT)
  ) u_pend (
    .clk     (clk),
    .rst     (rst),
    .set_en  (set_en),
    .set_idx (bus.s1_rt),
    .clr_en  (clr_en),
    .clr_idx (bus.s0_dst),
    .rd_idx  (rd_idx),
    .rd_busy (busy)
  );

  assign blk0 = busy[0] | (bus.s0_uses_rt & busy[1]);
  assign blk1 = busy[2] | (bus.s1_store & busy[3]);
  assign cnf  = bus.s0_wr & (bus.s0_dst != REG_ZERO) &
                ((bus.s0_dst == bus.s1_rs) |
                 ((bus.s1_store | bus.s1_load) & (bus.s0_dst == bus.s1_rt)));

  // Zero-cycle issue decision; reset and flush squash both slots.
  always_comb begin
    iss0      = 1'b0;
    iss1      = 1'b0;
    hold      = 1'b0;
    state_nxt = state;
    if (rst || bus.flush) begin
      state_nxt = ST_PAIR;
    end else if (state == ST_PAIR) begin
      if (bus.s0_valid && blk0) begin
        hold = 1'b1;
      end else if (!bus.s1_valid) begin
        iss0 = bus.s0_valid;
      end else if (!bus.s0_valid) begin
        iss1 = !blk1;
        hold = blk1;
      end else if (blk1 || cnf) begin
        iss0      = 1'b1;
        hold      = 1'b1;
        state_nxt = ST_SPLIT;
      end else begin
        iss0 = 1'b1;
        iss1 = 1'b1;
      end
    end else begin
      // Slot 0 already left; its result forwards, so only the scoreboard gates slot 1.
      iss1 = !blk1;
      hold = blk1;
      if (!blk1) state_nxt = ST_PAIR;
    end
  end

  assign set_en = iss1 & bus.s1_load & (bus.s1_rt != REG_ZERO);
  assign clr_en = iss0 & bus.s0_wr;

  // Pair/split state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_PAIR;
    else     state <= state_nxt;
  end

  // Saturating count of frozen front-end cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          stall_cnt <= '0;
    else if (hold && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
  end

  assign bus.iss0      = iss0;
  assign bus.iss1      = iss1;
  assign bus.hold      = hold;
  // High while slot 1 is still owed after this edge.
  assign bus.split     = (state_nxt == ST_SPLIT) & ~rst;
  assign bus.stall_cnt = stall_cnt;

endmodule

// File: tb/tb_dual_issue_scoreboard.sv
// Self-checking bench: directed pair scenarios plus random pairs against a time-based model.
module tb_dual_issue_scoreboard;
  import dual_issue_scoreboard_pkg::*;

  localparam int LAT = 1;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dual_issue_scoreboard_if #(.CNT_W(CW)) bus ();

  dual_issue_scoreboard #(.NREG(32), .LOAD_LAT(LAT), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  // Model: a register is readable from cycle ready_cyc[r] onward.
  int cyc;
  int ready_cyc [32];
  bit m_split;
  int m_stall;
  bit e_iss0, e_iss1, e_hold, e_nsplit;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit busy(input int r);
    return (r != 0) && (cyc < ready_cyc[r]);
  endfunction

  function automatic void model_reset();
    for (int r = 0; r < 32; r++) ready_cyc[r] = 0;
    m_split = 1'b0;
    m_stall = 0;
  endfunction

  function automatic void model_eval();
    bit b0, b1, cf;
    int s0d, s1r, s1t;
    s0d = int'(bus.s0_dst);
    s1r = int'(bus.s1_rs);
    s1t = int'(bus.s1_rt);
    b0 = busy(int'(bus.s0_rs)) || (bus.s0_uses_rt && busy(int'(bus.s0_rt)));
    b1 = busy(s1r) || (bus.s1_store && busy(s1t));
    cf = bus.s0_wr && (s0d != 0) &&
         ((s0d == s1r) || ((bus.s1_store || bus.s1_load) && s0d == s1t));
    e_iss0 = 0; e_iss1 = 0; e_hold = 0; e_nsplit = m_split;
    if (bus.flush) e_nsplit = 0;
    else if (!m_split) begin
      if (bus.s0_valid && b0)      e_hold = 1;
      else if (!bus.s1_valid)      e_iss0 = bus.s0_valid;
      else if (!bus.s0_valid)      begin e_iss1 = !b1; e_hold = b1; end
      else if (b1 || cf)           begin e_iss0 = 1; e_hold = 1; e_nsplit = 1; end
      else                         begin e_iss0 = 1; e_iss1 = 1; end
    end else begin
      e_iss1 = !b1; e_hold = b1; e_nsplit = b1;
    end
  endfunction

  function automatic void model_update();
    if (e_iss0 && bus.s0_wr && bus.s0_dst != 0) ready_cyc[int'(bus.s0_dst)] = cyc + 1;
    if (e_iss1 && bus.s1_load && bus.s1_rt != 0) ready_cyc[int'(bus.s1_rt)] = cyc + 1 + LAT;
    if (e_hold && m_stall < SAT) m_stall++;
    m_split = e_nsplit;
    cyc++;
  endfunction

  task automatic sample(input string tag);
    #1;
    model_eval();
    check({tag, ".iss0"},  32'(bus.iss0),      32'(e_iss0));
    check({tag, ".iss1"},  32'(bus.iss1),      32'(e_iss1));
    check({tag, ".hold"},  32'(bus.hold),      32'(e_hold));
    check({tag, ".split"}, 32'(bus.split),     32'(e_nsplit));
    check({tag, ".stall"}, 32'(bus.stall_cnt), 32'(m_stall));
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
  endtask

  task automatic rst_pulse(input string tag);
    #1 rst = 1'b1;
    #1;
    check({tag, ".rst_iss0"},  32'(bus.iss0),  0);
    check({tag, ".rst_iss1"},  32'(bus.iss1),  0);
    check({tag, ".rst_hold"},  32'(bus.hold),  0);
    check({tag, ".rst_split"}, 32'(bus.split), 0);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic set_s0(input bit v, input logic [5:0] op, input int rs, input int rt, input int dst);
    bus.s0_valid   = v;
    bus.s0_rs      = 5'(rs);
    bus.s0_rt      = 5'(rt);
    bus.s0_dst     = 5'(dst);
    bus.s0_wr      = v && op_s0_wr(op);
    bus.s0_uses_rt = v && op_s0_uses_rt(op);
  endtask

  task automatic set_s1(input bit v, input logic [5:0] op, input int rs, input int rt);
    bus.s1_valid = v;
    bus.s1_load  = v && (op == OP_LW);
    bus.s1_store = v && (op == OP_SW);
    bus.s1_rs    = 5'(rs);
    bus.s1_rt    = 5'(rt);
  endtask

  initial begin
    bit keep;
    rst = 1'b1;
    bus.flush = 1'b0;
    cyc = 0;
    model_reset();
    set_s0(1, OP_RTYPE, 1, 2, 3);
    set_s1(1, OP_LW, 5, 4);
    #2;
    check("reset.iss0",  32'(bus.iss0),      0);
    check("reset.iss1",  32'(bus.iss1),      0);
    check("reset.hold",  32'(bus.hold),      0);
    check("reset.split", 32'(bus.split),     0);
    check("reset.stall", 32'(bus.stall_cnt), 0);
    @(negedge clk);
    rst = 1'b0;

    // add $3,$1,$2 + lw $4,0($5), then add $6,$4,$4
    sample("ind");
    check("ind.both", 32'({bus.iss0, bus.iss1, bus.hold}), 32'b110);
    tick();
    @(negedge clk);
    set_s0(1, OP_RTYPE, 4, 4, 6);
    set_s1(0, OP_LW, 0, 0);
    sample("dep0");
    check("dep0.hold", 32'(bus.hold), 1);
    check("dep0.iss0", 32'(bus.iss0), 0);
    tick();
    @(negedge clk);
    sample("dep1");
    check("dep1.iss0",  32'(bus.iss0),      1);
    check("dep1.hold",  32'(bus.hold),      0);
    check("dep1.stall", 32'(bus.stall_cnt), 1);
    tick();

    // addi $8,$0,4 + sw $9,0($8)
    @(negedge clk);
    set_s0(1, OP_ADDI, 0, 8, 8);
    set_s1(1, OP_SW, 8, 9);
    sample("intra0");
    check("intra0.out", 32'({bus.iss0, bus.iss1, bus.hold, bus.split}), 32'b1011);
    tick();
    @(negedge clk);
    sample("intra1");
    check("intra1.out", 32'({bus.iss0, bus.iss1, bus.hold, bus.split}), 32'b0100);
    tick();

    // addi $4,$0,1 + lw $4,0($2); then add $5,$4,$0 must wait one cycle
    @(negedge clk);
    set_s0(1, OP_ADDI, 0, 4, 4);
    set_s1(1, OP_LW, 2, 4);
    sample("waw0");
    check("waw0.split", 32'(bus.split), 1);
    tick();
    @(negedge clk);
    sample("waw1");
    check("waw1.iss1", 32'(bus.iss1), 1);
    tick();
    @(negedge clk);
    set_s0(1, OP_RTYPE, 4, 0, 5);
    set_s1(0, OP_LW, 0, 0);
    sample("waw2");
    check("waw2.hold", 32'(bus.hold), 1);
    tick();
    @(negedge clk);
    sample("waw3");
    tick();

    // lw $0,0($1), then a pair reading $0
    @(negedge clk);
    set_s0(0, OP_RTYPE, 0, 0, 0);
    set_s1(1, OP_LW, 1, 0);
    sample("z0");
    tick();
    @(negedge clk);
    set_s0(1, OP_RTYPE, 0, 0, 2);
    set_s1(1, OP_SW, 0, 0);
    sample("z1");
    check("z1.out", 32'({bus.iss0, bus.iss1, bus.hold}), 32'b110);
    tick();

    // flush while in SPLIT
    @(negedge clk);
    set_s0(1, OP_ADDI, 0, 8, 8);
    set_s1(1, OP_SW, 8, 9);
    sample("fl0");
    tick();
    @(negedge clk);
    bus.flush = 1'b1;
    sample("fl1");
    check("fl1.out", 32'({bus.iss0, bus.iss1, bus.hold, bus.split}), 32'b0000);
    tick();
    @(negedge clk);
    bus.flush = 1'b0;
    set_s0(1, OP_RTYPE, 1, 2, 3);
    set_s1(1, OP_LW, 5, 10);
    sample("fl2");
    check("fl2.out", 32'({bus.iss0, bus.iss1}), 32'b11);
    tick();

    // reset pulse while pend[7] is set: consumer of $7 issues right after release
    @(negedge clk);
    set_s0(1, OP_RTYPE, 1, 2, 3);
    set_s1(1, OP_LW, 1, 7);
    sample("r0");
    tick();
    @(negedge clk);
    set_s0(1, OP_RTYPE, 7, 1, 11);
    set_s1(0, OP_LW, 0, 0);
    rst_pulse("r1");
    sample("r1");
    check("r1.out", 32'({bus.iss0, bus.hold}), 32'b10);
    check("r1.stall", 32'(bus.stall_cnt), 0);
    tick();

    // reset pulse mid-SPLIT: state returns to PAIR
    @(negedge clk);
    set_s0(1, OP_ADDI, 0, 8, 8);
    set_s1(1, OP_SW, 8, 9);
    sample("r2");
    tick();
    @(negedge clk);
    set_s0(1, OP_RTYPE, 7, 7, 12);
    set_s1(1, OP_LW, 5, 10);
    rst_pulse("r3");
    sample("r3");
    check("r3.out", 32'({bus.iss0, bus.iss1, bus.hold}), 32'b110);
    tick();

    // random pairs; decode holds its pair while hold is asserted
    keep = 1'b0;
    for (int k = 0; k < 900; k++) begin
      @(negedge clk);
      if (!keep) begin
        bus.s0_valid   = ($urandom_range(0, 7) != 0);
        bus.s0_rs      = 5'($urandom_range(0, 7));
        bus.s0_rt      = 5'($urandom_range(0, 7));
        bus.s0_dst     = 5'($urandom_range(0, 7));
        bus.s0_uses_rt = 1'($urandom_range(0, 1));
        bus.s0_wr      = 1'($urandom_range(0, 1));
        bus.s1_valid   = ($urandom_range(0, 3) != 0);
        bus.s1_load    = 1'($urandom_range(0, 1));
        bus.s1_store   = !bus.s1_load;
        bus.s1_rs      = 5'($urandom_range(0, 7));
        bus.s1_rt      = 5'($urandom_range(0, 7));
      end
      bus.flush = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 99) == 0) rst_pulse("rnd");
      sample("rnd");
      keep = e_hold;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
